hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock, `clk`; reset is synchronous and active-high, port `rst`, sampled on the rising edge of `clk`.
REQ-002 Ports SHALL be, one per line, as name / direction / width / meaning:
- `clk` / in / 1 / clock.
- `rst` / in / 1 / synchronous active-high reset.
- `id_valid` / in / 1 / decode holds a real instruction.
- `id_rs1`, `id_rs2` / in / 5 each / decode source registers.
- `id_use_rs1`, `id_use_rs2` / in / 1 each / the sources are read.
- `id_rd` / in / 5 / decode destination register.
- `id_regwrite`, `id_memread`, `id_branch` / in / 1 each / decode control bits.
- `ex_br_taken` / in / 1 / branch in EX resolved taken.
- `stall_pc` / out / 1 / hold PC.
- `stall_id` / out / 1 / hold IF/ID register.
- `flush_id` / out / 1 / squash IF/ID.
- `flush_ex` / out / 1 / insert bubble into ID/EX.
- `fwd_a`, `fwd_b` / out / 2 each / ALU operand select: 00 = register file, 10 = MEM result, 01 = WB result.
- `stall_cnt`, `flush_cnt` / out / 16 each / performance counters.

Function
REQ-003 Internal scoreboard SHALL hold three slots, EX, MEM and WB, each {valid, rd, rs1, rs2, use1, use2, regwrite, memread, branch}.
REQ-004 Each cycle the slots SHALL shift EX->MEM->WB; the EX slot loads decode fields only when `id_valid & ~stall_id & ~flush_ex`, otherwise it loads an invalid bubble.
REQ-005 A load-use hazard SHALL exist when all of the following hold:
- `id_valid`;
- EX.valid & EX.memread & EX.rd != 0;
- (`id_use_rs1` & `id_rs1` == EX.rd) or (`id_use_rs2` & `id_rs2` == EX.rd).
REQ-006 The FSM SHALL have states RUN, LDSTALL and FLUSH; its reset state is RUN.
REQ-007 In RUN, on a load-use hazard without `ex_br_taken`, the block SHALL:
- assert `stall_pc`, `stall_id` and `flush_ex` combinationally in that cycle;
- go to LDSTALL.
REQ-008 LDSTALL SHALL last exactly one cycle with all control outputs low and then return to RUN; the stalled instruction re-evaluates in RUN. A hazard that persists stalls again.
REQ-009 `ex_br_taken`, valid only when EX.valid & EX.branch, SHALL in any state:
- assert `flush_id` and `flush_ex` in that cycle;
- deassert `stall_pc` and `stall_id`;
- go to FLUSH.
REQ-010 `ex_br_taken` SHALL be ignored when EX.valid & EX.branch is false.
REQ-011 Branch flush SHALL take priority over load-use stall when both occur in the same cycle.
REQ-012 FLUSH SHALL assert `flush_id` for one further cycle, to discard the wrong-path fetch already registered, then return to RUN; a new `ex_br_taken` in FLUSH SHALL restart FLUSH.
REQ-013 `fwd_a` SHALL be computed combinationally from EX.rs1 and EX.use1:
- 10 if MEM.valid & MEM.regwrite & ~MEM.memread & MEM.rd == EX.rs1 & EX.rs1 != 0;
- else 01 if WB.valid & WB.regwrite & WB.rd == EX.rs1 & EX.rs1 != 0;
- else 00.
REQ-014 `fwd_b` SHALL be computed identically using EX.rs2 and EX.use2.
REQ-015 MEM forwarding SHALL take priority over WB forwarding; register x0 SHALL never forward.
REQ-016 `stall_cnt` SHALL increment on every cycle with `stall_pc` = 1; `flush_cnt` SHALL increment on every cycle with `ex_br_taken` accepted. Both SHALL saturate at 0xFFFF with no wrap.
REQ-017 All outputs other than the counters SHALL be pure functions of current inputs, FSM state and slots, with no extra latency.

Reset
REQ-018 While `rst` = 1 at a clock edge, the block SHALL:
- set FSM to RUN;
- clear all slot valid bits;
- zero both counters.
REQ-019 During and after reset all control outputs SHALL be 0, `fwd_a` = `fwd_b` = 00, and counters SHALL read 0.
REQ-020 Reset asserted mid-stall or mid-flush SHALL abandon the operation; the cycle after reset deasserts, behaviour is RUN with an empty scoreboard.

Verification
REQ-021 Load-use: `lw x5` in EX, decode `add x6,x5,x1` -> one cycle of `stall_pc`/`stall_id`/`flush_ex` = 1, then `fwd_a` = 01 when the add reaches EX, `stall_cnt` = 1.
REQ-022 Back-to-back ALU: `add x3` then `sub x4,x3,x3` -> no stall, `fwd_a` = `fwd_b` = 10; add a third dependent instruction after one gap -> 01.
REQ-023 Register x0: writer and reader both use rd = rs = x0 -> `fwd_a` = `fwd_b` = 00, no stall.
REQ-024 Branch plus load-use in the same cycle: `ex_br_taken` = 1 while the hazard holds -> `flush_id` = `flush_ex` = 1, `stall_pc` = 0, next cycle `flush_id` = 1 only, `flush_cnt` = 1, `stall_cnt` unchanged.
REQ-025 Saturation: preload 65535 stall cycles via a repeated hazard -> `stall_cnt` holds 0xFFFF.
REQ-026 Reset during FLUSH: `rst` = 1 -> all outputs 0 next cycle; a subsequent `add` runs with no residual flush.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
//   Tracks the instructions in EX/MEM/WB in a small scoreboard, detects
//   load-use hazards against the instruction in decode, handles taken-branch
//   flushes, selects ALU operand forwarding, and counts stall/flush cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid/id_rs1/id_rs2/...    decode-stage instruction fields
//   ex_br_taken                   branch in EX resolved taken
//   stall_pc, stall_id            hold PC and IF/ID register
//   flush_id, flush_ex            squash IF/ID, bubble into ID/EX
//   fwd_a, fwd_b                  00 = regfile, 10 = MEM result, 01 = WB result
//   stall_cnt, flush_cnt          saturating performance counters
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_branch,
  input  logic             ex_br_taken,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       regwrite;
    logic       memread;
    logic       branch;
  } slot_t;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    FLUSH
  } state_t;

  state_t            state_q, state_d;
  slot_t             ex_q, ex_d;
  slot_t             mem_q, mem_d;
  slot_t             wb_q, wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              br_acc;
  logic              load_use;
  logic              stall_pc_c, stall_id_c, flush_id_c, flush_ex_c;
  logic [1:0]        fwd_a_c, fwd_b_c;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input slot_t mem, input slot_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && rs != 5'd0) begin
      // Loads in MEM have no result yet; they can only forward from WB.
      if (mem.valid && mem.regwrite && !mem.memread && mem.rd == rs)
        sel = 2'b10;
      else if (wb.valid && wb.regwrite && wb.rd == rs)
        sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection and control FSM; a taken branch overrides everything.
  always_comb begin
    state_d    = state_q;
    stall_pc_c = 1'b0;
    stall_id_c = 1'b0;
    flush_id_c = 1'b0;
    flush_ex_c = 1'b0;

    br_acc   = ex_br_taken && ex_q.valid && ex_q.branch;
    load_use = id_valid && ex_q.valid && ex_q.memread && ex_q.rd != 5'd0 &&
               ((id_use_rs1 && id_rs1 == ex_q.rd) || (id_use_rs2 && id_rs2 == ex_q.rd));

    if (br_acc) begin
      flush_id_c = 1'b1;
      flush_ex_c = 1'b1;
      state_d    = FLUSH;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            stall_pc_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
            state_d    = LDSTALL;
          end
        end
        LDSTALL: state_d = RUN;
        FLUSH: begin
          flush_id_c = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Scoreboard shift: EX takes decode only when it is not stalled or bubbled.
  always_comb begin
    ex_d = '0;
    if (id_valid && !stall_id_c && !flush_ex_c) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.use1     = id_use_rs1;
      ex_d.use2     = id_use_rs2;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.branch   = id_branch;
    end
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_comb begin
    fwd_a_c = fwd_sel(ex_q.rs1, ex_q.use1, mem_q, wb_q);
    fwd_b_c = fwd_sel(ex_q.rs2, ex_q.use2, mem_q, wb_q);
  end

  // Outputs forced low while reset is held so nothing leaks from stale state.
  always_comb begin
    stall_pc = stall_pc_c & ~rst;
    stall_id = stall_id_c & ~rst;
    flush_id = flush_id_c & ~rst;
    flush_ex = flush_ex_c & ~rst;
    fwd_a    = rst ? 2'b00 : fwd_a_c;
    fwd_b    = rst ? 2'b00 : fwd_b_c;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br_acc && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. A second instance with 4-bit counters
// exercises counter saturation in a short run.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_regwrite, id_memread, id_branch;
  logic        ex_br_taken;
  logic        stall_pc, stall_id, flush_id, flush_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall_pc, s_stall_id, s_flush_id, s_flush_ex;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [3:0]  ctrl;
  logic [3:0]  fwd;
  int          checks = 0;
  int          failures = 0;

  assign ctrl = {stall_pc, stall_id, flush_id, flush_ex};
  assign fwd  = {fwd_a, fwd_b};

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_branch(id_branch),
    .ex_br_taken(ex_br_taken), .stall_pc(stall_pc), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_branch(id_branch),
    .ex_br_taken(ex_br_taken), .stall_pc(s_stall_pc), .stall_id(s_stall_id),
    .flush_id(s_flush_id), .flush_ex(s_flush_ex), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_branch   = br;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_br_taken = 1'b0;
    nop();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_br_taken = 1'b0;
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL rst_ctrl: got %b want 0000", ctrl); end
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL rst_fwd: got %b want 0000", fwd); end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      failures++; $display("FAIL rst_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    nop();
    #1;
    checks++;
    if (ctrl !== 4'b0000 || fwd !== 4'b0000) begin
      failures++; $display("FAIL rst_after: got ctrl=%b fwd=%b want 0000/0000", ctrl, fwd);
    end
  endtask

  // lw x5 in EX, add x6,x5,x1 in decode
  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL lu_pre: got %b want 0000", ctrl); end
    @(negedge clk);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b1101) begin failures++; $display("FAIL lu_stall: got %b want 1101", ctrl); end
    @(negedge clk);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL lu_ldstall: got %b want 0000", ctrl); end
    checks++;
    if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (fwd !== 4'b0100) begin failures++; $display("FAIL lu_fwd: got %b want 0100", fwd); end
    checks++;
    if (ctrl !== 4'b0000 || stall_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_post: got ctrl=%b cnt=%0d want 0000/1", ctrl, stall_cnt);
    end
  endtask

  // add x3; sub x4,x3,x3; gap; xor x8,x4,x3; then MEM-over-WB priority
  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL b2b_nostall: got %b want 0000", ctrl); end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (fwd !== 4'b1010) begin failures++; $display("FAIL b2b_mem: got %b want 1010", fwd); end
    @(negedge clk);
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (fwd !== 4'b0100) begin failures++; $display("FAIL b2b_wb: got %b want 0100", fwd); end
    // two writers of x9 back to back, then a reader: MEM copy wins
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (fwd !== 4'b1010) begin failures++; $display("FAIL b2b_prio: got %b want 1010", fwd); end
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL b2b_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL x0_nostall: got %b want 0000", ctrl); end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL x0_fwd: got %b want 0000", fwd); end
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL x0_load: got %b want 0000", ctrl); end
  endtask

  // ex_br_taken while EX holds a non-branch must do nothing
  task automatic test_branch_ignored();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nop();
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL br_ignored: got %b want 0000", ctrl); end
    @(negedge clk);
    ex_br_taken = 1'b0;
    #1;
    checks++;
    if (ctrl !== 4'b0000 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL br_ignored_post: got ctrl=%b cnt=%0d want 0000/0", ctrl, flush_cnt);
    end
  endtask

  // EX holds a load that is also a branch; decode depends on it; branch taken
  task automatic test_branch_load_use();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0011) begin failures++; $display("FAIL blu_flush: got %b want 0011", ctrl); end
    @(negedge clk);
    ex_br_taken = 1'b0;
    nop();
    #1;
    checks++;
    if (ctrl !== 4'b0010) begin failures++; $display("FAIL blu_flush2: got %b want 0010", ctrl); end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL blu_cnt: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL blu_done: got %b want 0000", ctrl); end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    @(negedge clk);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    nop();
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0011) begin failures++; $display("FAIL rf_branch: got %b want 0011", ctrl); end
    @(negedge clk);
    ex_br_taken = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin failures++; $display("FAIL rf_during: got %b want 0000", ctrl); end
    @(negedge clk);
    rst = 1'b0;
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrl !== 4'b0000 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL rf_after: got ctrl=%b cnt=%0d want 0000/0", ctrl, flush_cnt);
    end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (ctrl !== 4'b0000 || fwd !== 4'b0000) begin
      failures++; $display("FAIL rf_add: got ctrl=%b fwd=%b want 0000/0000", ctrl, fwd);
    end
  endtask

  // repeated lw x5 / add x6,x5 pairs; each pair is one stall cycle
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (ctrl !== 4'b1101) begin failures++; $display("FAIL sat_stall[%0d]: got %b want 1101", i, ctrl); end
      if (i == 14) begin
        @(negedge clk);
        nop();
        #1;
        checks++;
        if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd15) begin
          failures++; $display("FAIL sat_reach: got small=%0d main=%0d want 15/15", s_stall_cnt, stall_cnt);
        end
      end
    end
    @(negedge clk);
    nop();
    #1;
    checks++;
    if (s_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); end
    checks++;
    if (stall_cnt !== 16'd20) begin failures++; $display("FAIL sat_main: got %0d want 20", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    ex_br_taken = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_x0();
    test_branch_ignored();
    test_branch_load_use();
    test_reset_in_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
